info_frame_builder: RTL and testbench

//  Runtime-programmable HDMI InfoFrame source; generalises the fixed audio InfoFrame to any type/version/length.

---
 rtl/hdmi_infoframe_pkg.sv | 25 ++
 rtl/infoframe_checksum.sv | 32 +++
 rtl/info_frame_builder.sv | 143 ++++++++++++++
 tb/tb_info_frame_builder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_infoframe_pkg.sv
// Shared definitions for the runtime-programmable HDMI InfoFrame source:
// type codes, payload limit, commit FSM states and the header checksum helper.
package hdmi_infoframe_pkg;

   localparam logic [6:0] IF_TYPE_AVI   = 7'd2;
   localparam logic [6:0] IF_TYPE_SPD   = 7'd3;
   localparam logic [6:0] IF_TYPE_AUDIO = 7'd4;

   localparam int MAX_PB = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SUM,
      ST_CHECK,
      ST_SWAP
   } if_state_e;

   // Mod-256 sum of the three header bytes; seeds the payload checksum.
   function automatic logic [7:0] header_sum(input logic [6:0] if_type,
                                             input logic [7:0] version,
                                             input logic [4:0] length);
      return {1'b1, if_type} + version + {3'b000, length};
   endfunction

endpackage

// File: rtl/infoframe_checksum.sv
// Byte accumulator for the InfoFrame checksum: clear loads a seed, add folds in
// one byte per cycle, and chk_o is the byte that brings the total to zero.
module infoframe_checksum (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic [7:0] init_i,
   input  logic       add_i,
   input  logic [7:0] byte_i,
   output logic [7:0] chk_o
);

   logic [7:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clear_i)
         acc_d = init_i;
      else if (add_i)
         acc_d = acc_q + byte_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         acc_q <= 8'h00;
      else
         acc_q <= acc_d;
   end

   assign chk_o = 8'd0 - acc_q;

endmodule

// File: rtl/info_frame_builder.sv
// Programmable InfoFrame source: host fills a staging buffer, commit checksums it
// and swaps it into the active frame only while the packet assembler is idle.
module info_frame_builder
   import hdmi_infoframe_pkg::*;
#(
   parameter logic [6:0] TYPE    = IF_TYPE_AUDIO,
   parameter logic [7:0] VERSION = 8'd1,
   parameter logic [4:0] LENGTH  = 5'd10
) (
   input  logic              clk_pixel_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [4:0]        wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic              commit_i,
   input  logic              sending_i,
   output logic              busy_o,
   output logic              err_o,
   output logic              updated_o,
   output logic              frame_valid_o,
   output logic [23:0]       header_o,
   output logic [3:0][55:0]  sub_o
);

   localparam logic [7:0] HDR_SUM   = header_sum(TYPE, VERSION, LENGTH);
   localparam logic [7:0] RESET_CHK = 8'd0 - HDR_SUM;
   localparam logic [MAX_PB:0][7:0] ACTIVE_RST = {{MAX_PB{8'h00}}, RESET_CHK};

   if_state_e               state_q, state_d;
   logic [MAX_PB:0][7:0]    stage_q, stage_d;
   logic [MAX_PB:0][7:0]    active_q, active_d;
   logic [4:0]              idx_q, idx_d;
   logic [7:0]              chk_q, chk_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic                    upd_q, upd_d;
   logic                    fvalid_q, fvalid_d;
   logic                    cs_clear, cs_add;
   logic [7:0]              cs_chk;
   logic                    wr_ok;

   infoframe_checksum u_checksum (
      .clk_i   (clk_pixel_i),
      .reset_i (reset_i),
      .clear_i (cs_clear),
      .init_i  (HDR_SUM),
      .add_i   (cs_add),
      .byte_i  (stage_q[idx_q]),
      .chk_o   (cs_chk)
   );

   assign wr_ok = wr_en_i && (wr_addr_i != 5'd0) && (wr_addr_i <= LENGTH);

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      active_d = active_q;
      idx_d    = idx_q;
      chk_d    = chk_q;
      err_d    = 1'b0;
      upd_d    = 1'b0;
      fvalid_d = fvalid_q;
      cs_clear = 1'b0;
      cs_add   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A same-cycle write lands before the sum starts reading staging.
            if (wr_ok)
               stage_d[wr_addr_i] = wr_data_i;
            else if (wr_en_i)
               err_d = 1'b1;
            if (commit_i) begin
               state_d  = ST_SUM;
               idx_d    = 5'd1;
               cs_clear = 1'b1;
            end
         end
         ST_SUM: begin
            cs_add = 1'b1;
            if (idx_q == LENGTH)
               state_d = ST_CHECK;
            else
               idx_d = idx_q + 5'd1;
         end
         ST_CHECK: begin
            chk_d   = cs_chk;
            state_d = ST_SWAP;
         end
         ST_SWAP: begin
            if (!sending_i) begin
               for (int k = 1; k <= MAX_PB; k++)
                  if (k <= int'(LENGTH))
                     active_d[5'(k)] = stage_q[5'(k)];
               active_d[0] = chk_q;
               upd_d       = 1'b1;
               fvalid_d    = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && (wr_en_i || commit_i))
         err_d = 1'b1;

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_pixel_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         stage_q  <= '0;
         active_q <= ACTIVE_RST;
         idx_q    <= 5'd1;
         chk_q    <= 8'h00;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         upd_q    <= 1'b0;
         fvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         active_q <= active_d;
         idx_q    <= idx_d;
         chk_q    <= chk_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         upd_q    <= upd_d;
         fvalid_q <= fvalid_d;
      end
   end

   assign busy_o        = busy_q;
   assign err_o         = err_q;
   assign updated_o     = upd_q;
   assign frame_valid_o = fvalid_q;
   assign header_o      = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
   // PB bytes are stored little-endian, so the flat active array is already
   // {sub3, sub2, sub1, sub0} with PB[7i] in the low byte of sub[i].
   assign sub_o         = active_q;

endmodule

// File: tb/tb_info_frame_builder.sv
// Scoreboard bench: stimulus pushes expected frames / error events into queues,
// negedge monitors pop and compare whenever a DUT pulses updated or err.
module tb_info_frame_builder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              we0, cm0, snd0, busy0, err0, upd0, fv0;
   logic [4:0]        wa0;
   logic [7:0]        wd0;
   logic [23:0]       hdr0;
   logic [3:0][55:0]  sub0;

   logic              we1, cm1, snd1, busy1, err1, upd1, fv1;
   logic [4:0]        wa1;
   logic [7:0]        wd1;
   logic [23:0]       hdr1;
   logic [3:0][55:0]  sub1;

   info_frame_builder dut0 (
      .clk_pixel_i(clk), .reset_i(rst), .wr_en_i(we0), .wr_addr_i(wa0),
      .wr_data_i(wd0), .commit_i(cm0), .sending_i(snd0), .busy_o(busy0),
      .err_o(err0), .updated_o(upd0), .frame_valid_o(fv0), .header_o(hdr0),
      .sub_o(sub0)
   );

   info_frame_builder #(.TYPE(7'd3), .VERSION(8'd1), .LENGTH(5'd27)) dut1 (
      .clk_pixel_i(clk), .reset_i(rst), .wr_en_i(we1), .wr_addr_i(wa1),
      .wr_data_i(wd1), .commit_i(cm1), .sending_i(snd1), .busy_o(busy1),
      .err_o(err1), .updated_o(upd1), .frame_valid_o(fv1), .header_o(hdr1),
      .sub_o(sub1)
   );

   int checks = 0;
   int errors = 0;

   logic [223:0] exp0_q[$];
   logic [223:0] exp1_q[$];
   string        err0_q[$];

   localparam logic [223:0] F_RST0 = 224'h71;
   localparam logic [223:0] F_T2   = 224'h0170;
   localparam logic [223:0] F_T3   = {56'h0, 56'h0, 56'h00000022000000, 56'h00000000AB01A3};

   task automatic check_v(input string nm, input logic [223:0] act, input logic [223:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_i(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_sum(input logic [23:0] h, input logic [223:0] f);
      logic [7:0] s;
      s = h[7:0] + h[15:8] + h[23:16];
      for (int k = 0; k < 28; k++) s = s + f[k*8 +: 8];
      return s;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin : mon0
      logic [223:0] e;
      if (!rst && upd0) begin
         if (exp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0_unexpected_update: got frame %h expected no update", sub0);
         end else begin
            e = exp0_q.pop_front();
            check_v("dut0_frame", sub0, e);
         end
         check_i("dut0_invariant", int'(frame_sum(hdr0, sub0)), 0);
         check_i("dut0_fvalid_on_update", int'(fv0), 1);
         check_i("dut0_busy_on_update", int'(busy0), 0);
      end
      if (!rst && err0) begin
         if (err0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0_unexpected_err: got err=1 expected err=0");
         end else begin
            checks++;
            void'(err0_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [223:0] e;
      if (!rst && upd1) begin
         if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_unexpected_update: got frame %h expected no update", sub1);
         end else begin
            e = exp1_q.pop_front();
            check_v("dut1_frame", sub1, e);
         end
         check_i("dut1_invariant", int'(frame_sum(hdr1, sub1)), 0);
         for (int i = 0; i < 4; i++)
            check_i("dut1_sub_populated", int'(sub1[i] != 56'h0), 1);
      end
      if (!rst && err1) begin
         checks++; errors++;
         $display("FAIL dut1_unexpected_err: got err=1 expected err=0");
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr0(input logic [4:0] a, input logic [7:0] d);
      we0 = 1'b1; wa0 = a; wd0 = d; tick(); we0 = 1'b0;
   endtask

   task automatic commit0();
      cm0 = 1'b1; tick(); cm0 = 1'b0;
   endtask

   task automatic wait_upd(input int which, output int n);
      n = 0;
      while (((which == 0) ? upd0 : upd1) == 1'b0 && n < 300) begin
         tick(); n++;
      end
   endtask

   initial begin : stim
      int n;
      logic [27:0][7:0] f;
      logic [7:0] s;
      rst = 1'b1;
      we0 = 0; cm0 = 0; snd0 = 0; wa0 = '0; wd0 = '0;
      we1 = 0; cm1 = 0; snd1 = 0; wa1 = '0; wd1 = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: reset defaults
      check_v("rst_header0", 224'(hdr0), 224'h0A0184);
      check_v("rst_sub0", sub0, F_RST0);
      check_i("rst_fvalid0", int'(fv0), 0);
      check_i("rst_busy0", int'(busy0), 0);
      check_i("rst_err0", int'(err0), 0);
      check_i("rst_upd0", int'(upd0), 0);
      check_v("rst_header1", 224'(hdr1), 224'h1B0183);
      check_v("rst_sub1", sub1, 224'h61);

      // 2: PB1=1, commit, update 12 edges after the commit edge (cycle t+13)
      wr0(5'd1, 8'h01);
      exp0_q.push_back(F_T2);
      commit0();
      check_i("t2_busy_after_commit", int'(busy0), 1);
      wait_upd(0, n);
      check_i("t2_latency", n + 1, 13);
      check_v("t2_sub", sub0, F_T2);
      tick();
      check_i("t2_fvalid", int'(fv0), 1);

      // 3: swap blocked while sending
      wr0(5'd2, 8'hAB);
      wr0(5'd10, 8'h22);
      snd0 = 1'b1;
      exp0_q.push_back(F_T3);
      commit0();
      repeat (20) tick();
      check_i("t3_busy_held", int'(busy0), 1);
      check_v("t3_active_unchanged", sub0, F_T2);
      snd0 = 1'b0;
      tick();
      check_i("t3_swap_next_edge", int'(upd0), 1);
      check_v("t3_sub", sub0, F_T3);
      tick();

      // 4: rejected writes and commits
      err0_q.push_back("addr0");
      wr0(5'd0, 8'h5A);
      check_i("t4_err_addr0", int'(err0), 1);
      err0_q.push_back("addr11");
      wr0(5'd11, 8'h5A);
      check_i("t4_err_addr11", int'(err0), 1);
      check_i("t4_not_busy", int'(busy0), 0);
      exp0_q.push_back(F_T3);
      commit0();
      err0_q.push_back("wr_busy");
      wr0(5'd3, 8'hFF);
      check_i("t4_err_wr_busy", int'(err0), 1);
      err0_q.push_back("commit_busy");
      commit0();
      check_i("t4_err_commit_busy", int'(err0), 1);
      wait_upd(0, n);
      check_i("t4_latency_unaffected", n + 3, 13);
      tick();

      // 5: reset in the middle of SUM (idx==5)
      commit0();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_i("t5_busy_cleared", int'(busy0), 0);
      check_v("t5_sub_reset", sub0, F_RST0);
      check_i("t5_fvalid_cleared", int'(fv0), 0);
      check_i("t5_no_update", int'(upd0), 0);
      repeat (20) tick();
      check_v("t5_sub_still_reset", sub0, F_RST0);
      exp0_q.push_back(F_RST0);
      commit0();
      wait_upd(0, n);
      check_i("t5_recommit_latency", n + 1, 13);
      tick();

      // 6: LENGTH=27, TYPE=3, full payload
      f = '0;
      s = 8'h1B + 8'h01 + 8'h83;
      for (int k = 1; k <= 27; k++) begin
         f[5'(k)] = 8'(k * 29 + 7);
         s = s + f[5'(k)];
         we1 = 1'b1; wa1 = 5'(k); wd1 = f[5'(k)];
         tick();
      end
      we1 = 1'b0;
      f[0] = 8'd0 - s;
      exp1_q.push_back(f);
      cm1 = 1'b1; tick(); cm1 = 1'b0;
      wait_upd(1, n);
      check_i("t6_latency", n + 1, 30);
      repeat (3) tick();

      check_i("exp0_q_drained", exp0_q.size(), 0);
      check_i("exp1_q_drained", exp1_q.size(), 0);
      check_i("err0_q_drained", err0_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
